rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: three-requester round-robin arbiter feeding a single
// register-file write port. Grants are combinational; the winning address
// and data are registered into the write stage. Writes to register 0 are
// accepted but dropped. Combinational bypass flags compare the pending
// write against the two read pointers currently presented to the file.
module rf_write_arbiter #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         hold,
   input  logic [2:0]   req_valid,
   input  logic [D-1:0] req_addr0,
   input  logic [D-1:0] req_addr1,
   input  logic [D-1:0] req_addr2,
   input  logic [W-1:0] req_data0,
   input  logic [W-1:0] req_data1,
   input  logic [W-1:0] req_data2,
   output logic [2:0]   req_ready,
   output logic         write_en,
   output logic [D-1:0] waddr,
   output logic [W-1:0] data_in,
   input  logic [D-1:0] raddrA,
   input  logic [D-1:0] raddrB,
   output logic         fwd_hitA,
   output logic         fwd_hitB,
   output logic [W-1:0] fwd_data
);

   // Rotating-priority pick: first valid requester starting at pointer p.
   function automatic logic [2:0] pick(input logic [2:0] v, input logic [1:0] p);
      logic [2:0] g;
      g = 3'b000;
      case (p)
         2'd1: begin
            if (v[1])      g = 3'b010;
            else if (v[2]) g = 3'b100;
            else if (v[0]) g = 3'b001;
            else           g = 3'b000;
         end
         2'd2: begin
            if (v[2])      g = 3'b100;
            else if (v[0]) g = 3'b001;
            else if (v[1]) g = 3'b010;
            else           g = 3'b000;
         end
         default: begin
            if (v[0])      g = 3'b001;
            else if (v[1]) g = 3'b010;
            else if (v[2]) g = 3'b100;
            else           g = 3'b000;
         end
      endcase
      return g;
   endfunction

   logic [1:0]   ptr_q, ptr_d;
   logic         write_en_q, write_en_d;
   logic [D-1:0] waddr_q, waddr_d;
   logic [W-1:0] data_in_q, data_in_d;
   logic [2:0]   grant_s;
   logic         transfer_s;
   logic [D-1:0] sel_addr_s;
   logic [W-1:0] sel_data_s;

   // Grant: suppressed while frozen or in reset, otherwise rotating priority.
   always_comb begin
      grant_s = 3'b000;
      if (RESET || hold) begin
         grant_s = 3'b000;
      end else begin
         grant_s = pick(req_valid, ptr_q);
      end
   end

   assign transfer_s = |grant_s;

   // Route the winning requester's address/data and compute the next pointer.
   always_comb begin
      sel_addr_s = req_addr0;
      sel_data_s = req_data0;
      ptr_d      = ptr_q;
      case (grant_s)
         3'b001: begin
            sel_addr_s = req_addr0;
            sel_data_s = req_data0;
            ptr_d      = 2'd1;
         end
         3'b010: begin
            sel_addr_s = req_addr1;
            sel_data_s = req_data1;
            ptr_d      = 2'd2;
         end
         3'b100: begin
            sel_addr_s = req_addr2;
            sel_data_s = req_data2;
            ptr_d      = 2'd0;
         end
         default: begin
            sel_addr_s = req_addr0;
            sel_data_s = req_data0;
            ptr_d      = ptr_q;
         end
      endcase
   end

   // Write-stage next state: only a transfer to a nonzero register is written;
   // a register-0 transfer is consumed without touching the write stage.
   always_comb begin
      write_en_d = 1'b0;
      waddr_d    = waddr_q;
      data_in_d  = data_in_q;
      if (transfer_s && (sel_addr_s != {D{1'b0}})) begin
         write_en_d = 1'b1;
         waddr_d    = sel_addr_s;
         data_in_d  = sel_data_s;
      end else begin
         write_en_d = 1'b0;
         waddr_d    = waddr_q;
         data_in_d  = data_in_q;
      end
   end

   // Pointer and write-stage registers; reset clears any in-flight transfer.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr_q      <= 2'd0;
         write_en_q <= 1'b0;
         waddr_q    <= {D{1'b0}};
         data_in_q  <= {W{1'b0}};
      end else begin
         ptr_q      <= ptr_d;
         write_en_q <= write_en_d;
         waddr_q    <= waddr_d;
         data_in_q  <= data_in_d;
      end
   end

   assign req_ready = grant_s;
   assign write_en  = write_en_q;
   assign waddr     = waddr_q;
   assign data_in   = data_in_q;
   assign fwd_data  = data_in_q;
   // Port A never bypasses register 0; port B compares the pointer as-is.
   assign fwd_hitA  = write_en_q && (raddrA == waddr_q) && (raddrA != {D{1'b0}});
   assign fwd_hitB  = write_en_q && (raddrB == waddr_q);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a reference pointer model
// predicts grants, and a scoreboard queue holds expected writes until the
// write stage presents them.
module tb_rf_write_arbiter;
   localparam int W = 8;
   localparam int D = 3;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         hold;
   logic [2:0]   valid;
   logic [D-1:0] addr_a [3];
   logic [W-1:0] data_a [3];
   logic [2:0]   req_ready;
   logic         write_en;
   logic [D-1:0] waddr;
   logic [W-1:0] data_in;
   logic [D-1:0] raddrA, raddrB;
   logic         fwd_hitA, fwd_hitB;
   logic [W-1:0] fwd_data;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int           m_ptr;
   logic [D-1:0] m_waddr;
   logic [W-1:0] m_data;
   logic [D+W-1:0] sb [$];

   always #5 CLK = ~CLK;

   rf_write_arbiter #(.W(W), .D(D)) dut (
      .CLK(CLK), .RESET(RESET), .hold(hold), .req_valid(valid),
      .req_addr0(addr_a[0]), .req_addr1(addr_a[1]), .req_addr2(addr_a[2]),
      .req_data0(data_a[0]), .req_data1(data_a[1]), .req_data2(data_a[2]),
      .req_ready(req_ready), .write_en(write_en), .waddr(waddr), .data_in(data_in),
      .raddrA(raddrA), .raddrB(raddrB), .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB),
      .fwd_data(fwd_data)
   );

   // One arbitration cycle: check grant, push expected write, clock, check write stage.
   task automatic step(input string tag);
      logic [2:0]     exp_g;
      bit             found;
      bit             exp_we;
      int             sel;
      int             idx;
      logic [D+W-1:0] ent;
      #1;
      exp_g = 3'b000; found = 0; sel = 0; exp_we = 0;
      if (!hold) begin
         for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (!found && valid[idx]) begin
               found = 1; sel = idx; exp_g = 3'b001 << idx;
            end
         end
      end
      checks++;
      if (req_ready !== exp_g) begin
         failures++;
         $display("FAIL %s ready got=%b exp=%b", tag, req_ready, exp_g);
      end
      if (found) begin
         m_ptr = (sel + 1) % 3;
         if (addr_a[sel] != 3'd0) begin
            sb.push_back({addr_a[sel], data_a[sel]});
            exp_we = 1;
         end
      end
      @(posedge CLK); #1;
      checks++;
      if (write_en !== exp_we) begin
         failures++;
         $display("FAIL %s write_en got=%b exp=%b", tag, write_en, exp_we);
      end
      if (exp_we && sb.size() > 0) begin
         ent = sb.pop_front();
         m_waddr = ent[D+W-1:W];
         m_data  = ent[W-1:0];
      end
      checks++;
      if (waddr !== m_waddr || data_in !== m_data || fwd_data !== m_data) begin
         failures++;
         $display("FAIL %s wstage got=(%0d,%h,%h) exp=(%0d,%h)", tag, waddr, data_in, fwd_data, m_waddr, m_data);
      end
   endtask

   task automatic clear_model();
      m_ptr = 0; m_waddr = 3'd0; m_data = 8'h00;
      sb.delete();
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if (req_ready !== 3'b000 || write_en !== 1'b0 || waddr !== 3'd0 || data_in !== 8'h00
          || fwd_hitA !== 1'b0 || fwd_hitB !== 1'b0) begin
         failures++;
         $display("FAIL %s outputs got=(%b,%b,%0d,%h,%b,%b) exp all zero", tag,
                  req_ready, write_en, waddr, data_in, fwd_hitA, fwd_hitB);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; hold = 1'b0; valid = 3'b111;
      addr_a[0] = 3'd1; addr_a[1] = 3'd2; addr_a[2] = 3'd3;
      data_a[0] = 8'h11; data_a[1] = 8'h22; data_a[2] = 8'h33;
      raddrA = 3'd0; raddrB = 3'd0;
      clear_model();
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");
      valid = 3'b000;
      @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_round_robin();
      valid = 3'b111;
      for (int i = 0; i < 4; i++) step($sformatf("rr%0d", i));
      valid = 3'b000;
      step("rr_idle");
   endtask

   task automatic test_single();
      addr_a[1] = 3'd5; data_a[1] = 8'hA5;
      valid = 3'b010;
      step("single");
      valid = 3'b111;
      step("single_ptr2");
      valid = 3'b000;
      step("single_idle");
   endtask

   task automatic test_addr_zero();
      addr_a[0] = 3'd0; data_a[0] = 8'hFF;
      valid = 3'b001;
      step("addr0");
      valid = 3'b111;
      step("addr0_ptr1");
      addr_a[0] = 3'd1; data_a[0] = 8'h11;
      valid = 3'b000;
      step("addr0_idle");
   endtask

   task automatic test_hold();
      valid = 3'b101; hold = 1'b1;
      for (int i = 0; i < 4; i++) step($sformatf("hold%0d", i));
      hold = 1'b0;
      step("hold_rel0");
      step("hold_rel1");
      valid = 3'b000;
      step("hold_idle");
   endtask

   task automatic test_forward();
      addr_a[0] = 3'd4; data_a[0] = 8'h3C;
      valid = 3'b101; m_ptr = m_ptr; // ordering handled by model
      valid = 3'b001;
      step("fwd_wr");
      valid = 3'b000;
      raddrA = 3'd4; raddrB = 3'd0; #1;
      checks++;
      if (fwd_hitA !== 1'b1 || fwd_hitB !== 1'b0 || fwd_data !== 8'h3C) begin
         failures++;
         $display("FAIL fwdA got=(%b,%b,%h) exp=(1,0,3c)", fwd_hitA, fwd_hitB, fwd_data);
      end
      raddrA = 3'd0; raddrB = 3'd4; #1;
      checks++;
      if (fwd_hitA !== 1'b0 || fwd_hitB !== 1'b1) begin
         failures++;
         $display("FAIL fwdB got=(%b,%b) exp=(0,1)", fwd_hitA, fwd_hitB);
      end
      raddrA = 3'd4; raddrB = 3'd3; #1;
      checks++;
      if (fwd_hitA !== 1'b1 || fwd_hitB !== 1'b0) begin
         failures++;
         $display("FAIL fwdAB got=(%b,%b) exp=(1,0)", fwd_hitA, fwd_hitB);
      end
      step("fwd_idle");
      raddrA = 3'd4; raddrB = 3'd4; #1;
      checks++;
      if (fwd_hitA !== 1'b0 || fwd_hitB !== 1'b0) begin
         failures++;
         $display("FAIL fwd_nowrite got=(%b,%b) exp=(0,0)", fwd_hitA, fwd_hitB);
      end
      addr_a[0] = 3'd1; data_a[0] = 8'h11;
   endtask

   task automatic test_reset_mid();
      valid = 3'b111;
      step("mid_pre");
      raddrA = m_waddr; raddrB = m_waddr;
      #2;
      RESET = 1'b1;
      #1;
      check_zero("mid_reset");
      valid = 3'b000;
      #1;
      RESET = 1'b0;
      clear_model();
      step("mid_after");
      valid = 3'b111;
      step("mid_first");
      valid = 3'b000;
      step("mid_idle");
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_addr_zero();
      test_hold();
      test_forward();
      test_reset_mid();
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL scoreboard leftover=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
